// File: rtl/csr_port_arbiter_pkg.sv
// Shared types and constants for the CSR port arbiter and its trap sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: CSR_ARB_MTVAL_EN (adds the mtval write to the trap sequence).
package csr_port_arbiter_pkg;

    localparam int CSR_ADDR_W = 12;

    typedef logic [CSR_ADDR_W-1:0] csr_addr_t;

    // Request type understood by the CSR file.
    typedef enum logic [1:0] {
        CSR_RD = 2'd0,
        CSR_RW = 2'd1,
        CSR_RS = 2'd2,
        CSR_RC = 2'd3
    } csr_req_type_e;

    localparam csr_addr_t   CSR_MEPC    = 12'h341;
    localparam csr_addr_t   CSR_MCAUSE  = 12'h342;
    localparam csr_addr_t   CSR_MTVAL   = 12'h343;
    localparam csr_addr_t   CSR_MSTATUS = 12'h300;
    localparam logic [31:0] MSTATUS_MIE = 32'h0000_0008;

    // Arbiter states: the top uses IDLE/EXEC_LOCK, the trap sequencer IDLE/T_*.
    typedef enum logic [2:0] {
        IDLE,
        EXEC_LOCK,
        T_EPC,
        T_CAUSE,
`ifdef CSR_ARB_MTVAL_EN
        T_TVAL,
`endif
        T_STAT
    } arb_state_e;

endpackage

// File: rtl/csr_port_arbiter_if.sv
// CSR request channel: valid/ready request plus same-cycle read data and exists flag.
// Latency: n/a (signal bundle).
// Backpressure: requester holds valid/a/d/t stable until ready.
interface csr_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    import csr_port_arbiter_pkg::*;

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    csr_req_type_e     t;
    logic [DATA_W-1:0] rdata;
    logic              exists;

    // master issues requests, slave answers them
    modport master (output valid, a, d, t, input ready, rdata, exists);
    modport slave  (input valid, a, d, t, output ready, rdata, exists);

endinterface

// File: rtl/csr_port_arbiter_trap_seq.sv
// Trap entry sequencer: captures trap operands and issues mepc/mcause/[mtval]/mstatus writes.
// Latency: one write per csr_ready cycle after start; done/err registered one cycle after the last write.
// Backpressure: req_rdy_i low holds the current request stable indefinitely.
module csr_trap_seq
    import csr_port_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] cause_i,
    input  logic [DATA_W-1:0] tval_i,
    input  logic              req_rdy_i,
    input  logic              req_exists_i,
    output logic              req_vld_o,
    output logic [ADDR_W-1:0] req_a_o,
    output logic [DATA_W-1:0] req_d_o,
    output csr_req_type_e     req_t_o,
    output logic              seq_busy_o,
    output logic              done_o,
    output logic              err_o
);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] pc_q, cause_q;
    logic              err_q, err_d;
    logic              done_q, trap_err_q;
    logic              last_wr;

`ifdef CSR_ARB_MTVAL_EN
    logic [DATA_W-1:0] tval_q;
`else
    logic unused_tval;
    assign unused_tval = ^tval_i;
`endif

    // Next-state and request decode for the write sequence.
    always_comb begin
        state_d   = state_q;
        req_vld_o = 1'b0;
        req_a_o   = '0;
        req_d_o   = '0;
        req_t_o   = CSR_RW;
        last_wr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = T_EPC;
            end
            T_EPC: begin
                req_vld_o = 1'b1;
                req_a_o   = ADDR_W'(CSR_MEPC);
                req_d_o   = pc_q;
                if (req_rdy_i) state_d = T_CAUSE;
            end
            T_CAUSE: begin
                req_vld_o = 1'b1;
                req_a_o   = ADDR_W'(CSR_MCAUSE);
                req_d_o   = cause_q;
`ifdef CSR_ARB_MTVAL_EN
                if (req_rdy_i) state_d = T_TVAL;
`else
                if (req_rdy_i) state_d = T_STAT;
`endif
            end
`ifdef CSR_ARB_MTVAL_EN
            T_TVAL: begin
                req_vld_o = 1'b1;
                req_a_o   = ADDR_W'(CSR_MTVAL);
                req_d_o   = tval_q;
                if (req_rdy_i) state_d = T_STAT;
            end
`endif
            T_STAT: begin
                req_vld_o = 1'b1;
                req_a_o   = ADDR_W'(CSR_MSTATUS);
                req_d_o   = DATA_W'(MSTATUS_MIE);
                req_t_o   = CSR_RC;
                if (req_rdy_i) begin
                    state_d = IDLE;
                    last_wr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Error accumulator: cleared at trap acceptance, sticky across the sequence's handshakes.
    always_comb begin
        err_d = err_q;
        if (start_i) begin
            err_d = 1'b0;
        end else if (req_vld_o && req_rdy_i) begin
            err_d = err_q | ~req_exists_i;
        end
    end

    assign seq_busy_o = (state_q != IDLE);
    assign done_o     = done_q;
    assign err_o      = trap_err_q;

    // State, operand capture, and the registered completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            cause_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            trap_err_q <= 1'b0;
`ifdef CSR_ARB_MTVAL_EN
            tval_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            done_q     <= last_wr;
            trap_err_q <= last_wr & err_d;
            if (start_i) begin
                pc_q    <= pc_i;
                cause_q <= cause_i;
`ifdef CSR_ARB_MTVAL_EN
                tval_q  <= tval_i;
`endif
            end
        end
    end

endmodule

// File: rtl/csr_port_arbiter.sv
// Owns the CSR file port; grants it to atomic trap-entry sequences (priority) or exec ops (pass-through).
// Latency: exec 0 cycles; trap done 4 cycles after accept (5 with CSR_ARB_MTVAL_EN) when csr_ready is tied high.
// Backpressure: csr_ready low stalls the granted requester; grant never moves while a request is outstanding.
module csr_port_arbiter
    import csr_port_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    csr_port_arbiter_if.slave    exec_if,
    input  logic                 trap_valid,
    output logic                 trap_ready,
    input  logic [DATA_W-1:0]    trap_pc,
    input  logic [DATA_W-1:0]    trap_cause,
    input  logic [DATA_W-1:0]    trap_tval,
    output logic                 trap_done,
    output logic                 trap_err,
    csr_port_arbiter_if.master   csr_if
);

    arb_state_e        state_q, state_d;
    logic              exec_gnt;
    logic              seq_start;
    logic              seq_busy;
    logic              seq_vld;
    logic [ADDR_W-1:0] seq_a;
    logic [DATA_W-1:0] seq_d;
    csr_req_type_e     seq_t;

    csr_trap_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_trap_seq (
        .clk          (clk),
        .rst          (rst),
        .start_i      (seq_start),
        .pc_i         (trap_pc),
        .cause_i      (trap_cause),
        .tval_i       (trap_tval),
        .req_rdy_i    (csr_if.ready),
        .req_exists_i (csr_if.exists),
        .req_vld_o    (seq_vld),
        .req_a_o      (seq_a),
        .req_d_o      (seq_d),
        .req_t_o      (seq_t),
        .seq_busy_o   (seq_busy),
        .done_o       (trap_done),
        .err_o        (trap_err)
    );

    // Grant decision: trap beats exec in IDLE; a stalled exec op locks the port until its handshake.
    always_comb begin
        state_d    = state_q;
        exec_gnt   = 1'b0;
        seq_start  = 1'b0;
        trap_ready = 1'b0;
        case (state_q)
            EXEC_LOCK: begin
                exec_gnt = 1'b1;
                if (csr_if.ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                if (!seq_busy) begin
                    if (trap_valid) begin
                        trap_ready = 1'b1;
                        seq_start  = 1'b1;
                    end else if (exec_if.valid) begin
                        exec_gnt = 1'b1;
                        if (!csr_if.ready) state_d = EXEC_LOCK;
                    end
                end
            end
        endcase
    end

    // Port mux: exec is a combinational pass-through, otherwise the trap sequencer drives the port.
    always_comb begin
        csr_if.valid   = seq_vld;
        csr_if.a       = seq_a;
        csr_if.d       = seq_d;
        csr_if.t       = seq_t;
        exec_if.ready  = exec_gnt & csr_if.ready;
        exec_if.rdata  = csr_if.rdata;
        exec_if.exists = csr_if.exists;
        if (exec_gnt) begin
            csr_if.valid = 1'b1;
            csr_if.a     = exec_if.a;
            csr_if.d     = exec_if.d;
            csr_if.t     = exec_if.t;
        end
    end

    // Grant/lock state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Directed bench for csr_port_arbiter: exec pass-through, trap sequence, priority, lock, error, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Trap sequence length follows CSR_ARB_MTVAL_EN.
module tb_csr_port_arbiter;
    import csr_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid;
    logic        trap_ready;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        trap_done;
    logic        trap_err;

    int total  = 0;
    int passed = 0;

    csr_port_arbiter_if #(.DATA_W(32), .ADDR_W(12)) exec_bus ();
    csr_port_arbiter_if #(.DATA_W(32), .ADDR_W(12)) csr_bus ();

    always #5 clk = ~clk;

    csr_port_arbiter #(.DATA_W(32), .ADDR_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .exec_if    (exec_bus),
        .trap_valid (trap_valid),
        .trap_ready (trap_ready),
        .trap_pc    (trap_pc),
        .trap_cause (trap_cause),
        .trap_tval  (trap_tval),
        .trap_done  (trap_done),
        .trap_err   (trap_err),
        .csr_if     (csr_bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_req(input string tag, input logic [11:0] a, input logic [31:0] d, input logic [1:0] t);
        chk({tag, "_valid"}, 32'(csr_bus.valid), 32'd1);
        chk({tag, "_a"},     32'(csr_bus.a),     32'(a));
        chk({tag, "_d"},     csr_bus.d,          d);
        chk({tag, "_t"},     32'(csr_bus.t),     32'(t));
    endtask

    initial begin
        rst            = 1'b0;
        trap_valid     = 1'b0;
        trap_pc        = '0;
        trap_cause     = '0;
        trap_tval      = '0;
        exec_bus.valid = 1'b0;
        exec_bus.a     = '0;
        exec_bus.d     = '0;
        exec_bus.t     = CSR_RD;
        csr_bus.ready  = 1'b0;
        csr_bus.rdata  = '0;
        csr_bus.exists = 1'b0;

        // reset state
        #12;
        chk("rst_csr_valid",  32'(csr_bus.valid),  32'd0);
        chk("rst_exec_ready", 32'(exec_bus.ready), 32'd0);
        chk("rst_trap_ready", 32'(trap_ready),     32'd0);
        chk("rst_trap_done",  32'(trap_done),      32'd0);
        chk("rst_trap_err",   32'(trap_err),       32'd0);
        rst = 1'b1;

        // exec RW pass-through, zero latency
        tick();
        exec_bus.valid = 1'b1;
        exec_bus.a     = 12'h340;
        exec_bus.d     = 32'h55;
        exec_bus.t     = CSR_RW;
        csr_bus.ready  = 1'b1;
        csr_bus.rdata  = 32'h12;
        csr_bus.exists = 1'b1;
        settle();
        chk_req("exec1", 12'h340, 32'h55, 2'd1);
        chk("exec1_ready",  32'(exec_bus.ready),  32'd1);
        chk("exec1_rdata",  exec_bus.rdata,       32'h12);
        chk("exec1_exists", 32'(exec_bus.exists), 32'd1);
        tick();
        exec_bus.valid = 1'b0;
        settle();
        chk("exec1_idle_valid", 32'(csr_bus.valid), 32'd0);

        // trap and exec together: trap wins, exec waits for trap_done
        tick();
        trap_valid     = 1'b1;
        trap_pc        = 32'h8000_0100;
        trap_cause     = 32'h2;
        trap_tval      = 32'hdead;
        exec_bus.valid = 1'b1;
        exec_bus.a     = 12'h305;
        exec_bus.d     = 32'h77;
        exec_bus.t     = CSR_RW;
        csr_bus.rdata  = 32'h99;
        settle();
        chk("t1_trap_ready",  32'(trap_ready),     32'd1);
        chk("t1_exec_ready0", 32'(exec_bus.ready), 32'd0);
        chk("t1_csr_valid0",  32'(csr_bus.valid),  32'd0);
        tick();
        trap_valid = 1'b0;
        trap_pc    = 32'hffff_ffff;
        trap_cause = 32'hffff_ffff;
        trap_tval  = 32'hffff_ffff;
        settle();
        chk_req("t1_epc", 12'h341, 32'h8000_0100, 2'd1);
        chk("t1_epc_exec_ready", 32'(exec_bus.ready), 32'd0);
        tick();
        settle();
        chk_req("t1_cause", 12'h342, 32'h2, 2'd1);
`ifdef CSR_ARB_MTVAL_EN
        tick();
        settle();
        chk_req("t1_tval", 12'h343, 32'hdead, 2'd1);
`endif
        tick();
        settle();
        chk_req("t1_stat", 12'h300, 32'h8, 2'd3);
        chk("t1_stat_exec_ready", 32'(exec_bus.ready), 32'd0);
        chk("t1_stat_done0",      32'(trap_done),      32'd0);
        tick();
        settle();
        chk("t1_done",       32'(trap_done),      32'd1);
        chk("t1_err",        32'(trap_err),       32'd0);
        chk("t1_exec_a",     32'(csr_bus.a),      32'h305);
        chk("t1_exec_ready", 32'(exec_bus.ready), 32'd1);
        chk("t1_exec_rdata", exec_bus.rdata,      32'h99);
        tick();
        exec_bus.valid = 1'b0;
        settle();
        chk("t1_done_pulse", 32'(trap_done),     32'd0);
        chk("t1_idle_valid", 32'(csr_bus.valid), 32'd0);

        // stalled exec locks the port against a later trap
        tick();
        exec_bus.valid = 1'b1;
        exec_bus.a     = 12'h300;
        exec_bus.d     = 32'h1;
        exec_bus.t     = CSR_RS;
        csr_bus.ready  = 1'b0;
        settle();
        chk("lk0_a",     32'(csr_bus.a),      32'h300);
        chk("lk0_t",     32'(csr_bus.t),      32'd2);
        chk("lk0_ready", 32'(exec_bus.ready), 32'd0);
        tick();
        trap_valid = 1'b1;
        trap_pc    = 32'h1000;
        trap_cause = 32'hb;
        trap_tval  = 32'h7;
        settle();
        chk("lk1_trap_ready", 32'(trap_ready),    32'd0);
        chk("lk1_a",          32'(csr_bus.a),     32'h300);
        chk("lk1_valid",      32'(csr_bus.valid), 32'd1);
        tick();
        settle();
        chk("lk2_trap_ready", 32'(trap_ready), 32'd0);
        chk("lk2_a",          32'(csr_bus.a),  32'h300);
        tick();
        csr_bus.ready = 1'b1;
        settle();
        chk("lk3_exec_ready", 32'(exec_bus.ready), 32'd1);
        chk("lk3_trap_ready", 32'(trap_ready),     32'd0);
        tick();
        exec_bus.valid = 1'b0;
        settle();
        chk("lk4_trap_ready", 32'(trap_ready),    32'd1);
        chk("lk4_csr_valid",  32'(csr_bus.valid), 32'd0);

        // missing CSR during mcause write, with a stall cycle first
        tick();
        trap_valid = 1'b0;
        settle();
        chk_req("t2_epc", 12'h341, 32'h1000, 2'd1);
        tick();
        csr_bus.ready = 1'b0;
        settle();
        chk_req("t2_cause_stall", 12'h342, 32'hb, 2'd1);
        tick();
        csr_bus.ready  = 1'b1;
        csr_bus.exists = 1'b0;
        settle();
        chk_req("t2_cause", 12'h342, 32'hb, 2'd1);
`ifdef CSR_ARB_MTVAL_EN
        tick();
        csr_bus.exists = 1'b1;
        settle();
        chk_req("t2_tval", 12'h343, 32'h7, 2'd1);
`endif
        tick();
        csr_bus.exists = 1'b1;
        settle();
        chk_req("t2_stat", 12'h300, 32'h8, 2'd3);
        tick();
        trap_valid = 1'b1;
        trap_pc    = 32'h2000;
        trap_cause = 32'h3;
        trap_tval  = 32'h0;
        settle();
        chk("t2_done",          32'(trap_done),  32'd1);
        chk("t2_err",           32'(trap_err),   32'd1);
        chk("t3_accept_in_done", 32'(trap_ready), 32'd1);

        // back-to-back trap, all CSRs exist: error cleared
        tick();
        trap_valid = 1'b0;
        settle();
        chk("t3_done_pulse", 32'(trap_done), 32'd0);
        chk_req("t3_epc", 12'h341, 32'h2000, 2'd1);
        tick();
        settle();
        chk_req("t3_cause", 12'h342, 32'h3, 2'd1);
`ifdef CSR_ARB_MTVAL_EN
        tick();
        settle();
        chk_req("t3_tval", 12'h343, 32'h0, 2'd1);
`endif
        tick();
        settle();
        chk_req("t3_stat", 12'h300, 32'h8, 2'd3);
        tick();
        settle();
        chk("t3_done", 32'(trap_done), 32'd1);
        chk("t3_err",  32'(trap_err),  32'd0);

        // reset in the middle of a trap sequence
        tick();
        trap_valid = 1'b1;
        trap_pc    = 32'h3000;
        trap_cause = 32'h5;
        settle();
        chk("t4_trap_ready", 32'(trap_ready), 32'd1);
        tick();
        trap_valid = 1'b0;
        settle();
        chk_req("t4_epc", 12'h341, 32'h3000, 2'd1);
        tick();
        settle();
        chk_req("t4_cause", 12'h342, 32'h5, 2'd1);
        rst = 1'b0;
        settle();
        chk("t4_rst_valid", 32'(csr_bus.valid), 32'd0);
        chk("t4_rst_done",  32'(trap_done),     32'd0);
        tick();
        settle();
        chk("t4_rst_valid2", 32'(csr_bus.valid), 32'd0);
        chk("t4_rst_done2",  32'(trap_done),     32'd0);
        rst = 1'b1;
        tick();
        settle();
        chk("t4_post_valid", 32'(csr_bus.valid), 32'd0);
        chk("t4_post_done",  32'(trap_done),     32'd0);
        tick();
        settle();
        chk("t4_post_done2", 32'(trap_done), 32'd0);
        tick();
        settle();
        chk("t4_post_done3", 32'(trap_done), 32'd0);
        exec_bus.valid = 1'b1;
        exec_bus.a     = 12'h344;
        exec_bus.d     = 32'ha;
        exec_bus.t     = CSR_RW;
        settle();
        chk("t4_exec_a",     32'(csr_bus.a),      32'h344);
        chk("t4_exec_ready", 32'(exec_bus.ready), 32'd1);
        tick();
        exec_bus.valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
